// File: rtl/serial_compare4.sv
// Bit-serial magnitude comparator, operands MSB first.
// The first differing bit decides; if none differs, the cascade input decides.
module serial_compare4 #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] comp_in,
  input  logic       bit_valid,
  input  logic       a_bit,
  input  logic       b_bit,
  output logic [2:0] o,
  output logic       done,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             gt, gt_n;
  logic             lt, lt_n;
  logic [2:0]       cin_r, cin_n;
  logic [2:0]       o_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      gt    <= 1'b0;
      lt    <= 1'b0;
      cin_r <= 3'b010;
      o     <= 3'b000;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      gt    <= gt_n;
      lt    <= lt_n;
      cin_r <= cin_n;
      o     <= o_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    gt_n    = gt;
    lt_n    = lt;
    cin_n   = cin_r;
    o_n     = o;
    unique case (state)
      IDLE: begin
        if (start) begin
          cin_n   = $onehot(comp_in) ? comp_in : 3'b010;
          cnt_n   = '0;
          gt_n    = 1'b0;
          lt_n    = 1'b0;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_valid) begin
          cnt_n = cnt + 1'b1;
          // Only the most significant differing bit matters.
          if (!gt && !lt && (a_bit != b_bit)) begin
            gt_n = a_bit;
            lt_n = b_bit;
          end
          if (cnt == LAST) begin
            state_n = DONE;
            if (gt_n)      o_n = 3'b100;
            else if (lt_n) o_n = 3'b001;
            else           o_n = cin_r;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign done = (state == DONE);
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial_compare4.sv
// Randomized and directed bench for serial_compare4.
// Expected results come from an arithmetic model of the compare.
module tb_serial_compare4;

  localparam int W = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] comp_in = 3'b010;
  logic       bit_valid = 1'b0;
  logic       a_bit = 1'b0;
  logic       b_bit = 1'b0;
  logic [2:0] o;
  logic       done;
  logic       busy;

  int checks = 0;
  int errors = 0;

  serial_compare4 #(.WIDTH(W), .CNT_W(3)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .comp_in(comp_in),
    .bit_valid(bit_valid),
    .a_bit(a_bit),
    .b_bit(b_bit),
    .o(o),
    .done(done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] model(input int a, input int b,
                                       input logic [2:0] cin);
    if (a > b) return 3'b100;
    if (a < b) return 3'b001;
    if (cin == 3'b100 || cin == 3'b010 || cin == 3'b001) return cin;
    return 3'b010;
  endfunction

  task automatic do_cmp(input string name, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [2:0] cin,
                        input int stall_before, input int stall_len,
                        input bit rnd, input bit poke);
    logic [2:0] exp;
    int lat;
    int stalls;
    int early;
    exp = model(int'(a), int'(b), cin);
    lat = 0;
    stalls = 0;
    early = 0;
    start = 1'b1;
    comp_in = cin;
    tick();
    lat++;
    start = 1'b0;
    comp_in = 3'($urandom);
    for (int i = W - 1; i >= 0; i--) begin
      int s;
      s = rnd ? int'($urandom_range(0, 2))
              : (((W - 1 - i) == stall_before) ? stall_len : 0);
      for (int k = 0; k < s; k++) begin
        bit_valid = 1'b0;
        a_bit = 1'($urandom);
        b_bit = 1'($urandom);
        start = poke;
        if (poke) comp_in = 3'b100;
        tick();
        lat++;
        stalls++;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          errors++;
          $display("FAIL %s stall busy/done got %b/%b want 1/0",
                   name, busy, done);
        end
      end
      bit_valid = 1'b1;
      a_bit = a[i];
      b_bit = b[i];
      start = poke;
      if (poke) comp_in = 3'b100;
      tick();
      lat++;
      if (i != 0 && done) early++;
    end
    bit_valid = 1'b0;
    start = 1'b0;
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL %s early_done got %0d want 0", name, early);
    end
    while (!done && lat < 64) begin
      tick();
      lat++;
    end
    checks++;
    if (done !== 1'b1 || lat != W + 1 + stalls) begin
      errors++;
      $display("FAIL %s latency got done=%b lat=%0d want lat=%0d",
               name, done, lat, W + 1 + stalls);
    end
    checks++;
    if (o !== exp || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s result got o=%b busy=%b want o=%b busy=1",
               name, o, busy, exp);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || o !== exp) begin
      errors++;
      $display("FAIL %s after got done=%b busy=%b o=%b want 0 0 %b",
               name, done, busy, o, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    comp_in = 3'b100;
    tick();
    tick();
    rst_n = 1'b1;
    start = 1'b0;
    checks++;
    if (o !== 3'b000 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset got o=%b done=%b busy=%b want 000 0 0",
               o, done, busy);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || o !== 3'b000) begin
      errors++;
      $display("FAIL reset_idle got busy=%b o=%b want 0 000", busy, o);
    end
  endtask

  task automatic test_basic();
    do_cmp("gt", 4'b1000, 4'b0010, 3'b010, 0, 0, 1'b0, 1'b0);
    do_cmp("lt", 4'b0010, 4'b0110, 3'b010, 0, 0, 1'b0, 1'b0);
    do_cmp("eq", 4'b0100, 4'b0100, 3'b010, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_cascade();
    do_cmp("casc_gt", 4'b1100, 4'b1100, 3'b100, 0, 0, 1'b0, 1'b0);
    do_cmp("casc_lt", 4'b1100, 4'b1100, 3'b001, 0, 0, 1'b0, 1'b0);
    do_cmp("casc_bad", 4'b1100, 4'b1100, 3'b011, 0, 0, 1'b0, 1'b0);
    do_cmp("casc_zero", 4'b0000, 4'b0000, 3'b000, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_stall();
    do_cmp("stall", 4'b0100, 4'b1100, 3'b010, 2, 3, 1'b0, 1'b0);
  endtask

  task automatic test_start_ignored();
    do_cmp("poke", 4'b0011, 4'b0101, 3'b010, 1, 2, 1'b0, 1'b1);
  endtask

  task automatic test_abort();
    int seen;
    seen = 0;
    start = 1'b1;
    comp_in = 3'b010;
    tick();
    start = 1'b0;
    bit_valid = 1'b1;
    a_bit = 1'b1;
    b_bit = 1'b0;
    tick();
    a_bit = 1'b0;
    tick();
    bit_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (o !== 3'b000 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort got o=%b done=%b busy=%b want 000 0 0",
               o, done, busy);
    end
    for (int k = 0; k < 6; k++) begin
      tick();
      if (done) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_nodone got %0d pulses want 0", seen);
    end
    do_cmp("post_abort", 4'b0000, 4'b0001, 3'b010, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      do_cmp("rand", 4'($urandom), 4'($urandom), 3'($urandom),
             0, 0, 1'b1, 1'($urandom));
    end
  endtask

  task automatic test_back_to_back();
    // Next compare starts in the very cycle after done.
    for (int n = 0; n < 4; n++) begin
      do_cmp("b2b", 4'($urandom), 4'($urandom), 3'b010,
             0, 0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cascade();
    test_stall();
    test_start_ignored();
    test_abort();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
